// File: rtl/fm_cmn_pkg.sv
// fm_cmn_pkg: constants shared by the fm_cmn buffering blocks.
//   OQ_DEPTH   output-queue entries behind the block RAM
//   cnt_width  width of an occupancy count for a RAM of 2**range entries
//   ERR_*      bit positions of the individual error sources
package fm_cmn_pkg;

  localparam int unsigned OQ_DEPTH = 2;

  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_UDF = 1;
  localparam int unsigned ERR_NUM = 2;

  // RAM count reaches 2**range, plus in-flight word and output queue
  function automatic int unsigned cnt_width(input int unsigned range);
    return range + 2;
  endfunction

endpackage

// File: rtl/fm_cmn_bram_02.sv
// fm_cmn_bram_02: simple dual-port block RAM.
// Port A writes (read-first on doa), port B reads with 1-cycle registered
// latency; a same-address write on A returns the old word on B.
module fm_cmn_bram_02 #(
  parameter int unsigned P_WIDTH = 32,
  parameter int unsigned P_RANGE = 4
) (
  input  logic               clka,
  input  logic               wea,
  input  logic [P_RANGE-1:0] addra,
  input  logic [P_WIDTH-1:0] dia,
  output logic [P_WIDTH-1:0] doa,
  input  logic               clkb,
  input  logic [P_RANGE-1:0] addrb,
  output logic [P_WIDTH-1:0] dob
);

  logic [P_WIDTH-1:0] mem [1 << P_RANGE];

  // port A: write, registered read-first readback
  always_ff @(posedge clka) begin
    if (wea) mem[addra] <= dia;
    doa <= mem[addra];
  end

  // port B: registered read
  always_ff @(posedge clkb) begin
    dob <= mem[addrb];
  end

endmodule

// File: rtl/fm_cmn_bfifo.sv
// fm_cmn_bfifo: single-clock show-ahead FIFO built on fm_cmn_bram_02 with a
// 2-entry output queue giving a valid/ack head interface at 1 word/cycle.
// Optional build macro FM_CMN_BFIFO_ERR_EN enables the sticky o_err flag
// (overflow write or underflow ack); otherwise o_err is tied low.
module fm_cmn_bfifo
  import fm_cmn_pkg::*;
#(
  parameter int unsigned P_WIDTH = 32,
  parameter int unsigned P_RANGE = 4
) (
  input  logic                           clk_core,
  input  logic                           rst_core,
  input  logic                           i_wr,
  input  logic [P_WIDTH-1:0]             i_wdt,
  output logic                           o_full,
  output logic                           o_valid,
  output logic [P_WIDTH-1:0]             o_dt,
  input  logic                           i_ack,
  output logic [cnt_width(P_RANGE)-1:0]  o_count,
  output logic                           o_err
);

  localparam int unsigned P_DEPTH = 1 << P_RANGE;
  localparam int unsigned RW      = P_RANGE;
  localparam int unsigned MW      = P_RANGE + 1;
  localparam int unsigned CW      = cnt_width(P_RANGE);
  localparam logic [MW-1:0] L_FULL = MW'(P_DEPTH);
  localparam logic [2:0]    L_OQD  = 3'(OQ_DEPTH);

  logic [RW-1:0]      wptr;
  logic [RW-1:0]      rptr;
  logic [MW-1:0]      mem_cnt;
  logic [MW-1:0]      mem_cnt_nx;
  logic               full_q;
  logic               fetch_pend;
  logic [1:0]         oq_cnt;
  logic [P_WIDTH-1:0] oq_0;
  logic [P_WIDTH-1:0] oq_1;
  logic [P_WIDTH-1:0] dob;
  logic               wr_ok;
  logic               pop;
  logic               fetch;
  logic [2:0]         occ;

  assign wr_ok = i_wr & ~full_q;
  assign pop   = i_ack & o_valid;

  // Fetch only when the word will have a queue slot on return, counting
  // the word already in flight and the slot freed by this cycle's pop.
  assign occ   = {1'b0, oq_cnt} + {2'b00, fetch_pend};
  assign fetch = (mem_cnt != '0) && (occ < (L_OQD + {2'b00, pop}));

  assign mem_cnt_nx = mem_cnt + MW'(wr_ok) - MW'(fetch);

  fm_cmn_bram_02 #(
    .P_WIDTH (P_WIDTH),
    .P_RANGE (P_RANGE)
  ) u_bram (
    .clka  (clk_core),
    .wea   (wr_ok),
    .addra (wptr),
    .dia   (i_wdt),
    .doa   (),
    .clkb  (clk_core),
    .addrb (rptr),
    .dob   (dob)
  );

  // pointers, RAM occupancy, full flag and fetch-in-flight marker
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      wptr       <= '0;
      rptr       <= '0;
      mem_cnt    <= '0;
      full_q     <= 1'b0;
      fetch_pend <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + RW'(1);
      if (fetch) rptr <= rptr + RW'(1);
      mem_cnt    <= mem_cnt_nx;
      full_q     <= (mem_cnt_nx == L_FULL);
      fetch_pend <= fetch;
    end
  end

  // output queue: returned RAM word pushed at tail, head popped on ack
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      oq_cnt <= '0;
      oq_0   <= '0;
      oq_1   <= '0;
    end else begin
      case ({fetch_pend, pop})
        2'b01: begin
          oq_0   <= oq_1;
          oq_cnt <= oq_cnt - 2'd1;
        end
        2'b10: begin
          if (oq_cnt == 2'd0) oq_0 <= dob;
          else                oq_1 <= dob;
          oq_cnt <= oq_cnt + 2'd1;
        end
        2'b11: begin
          if (oq_cnt == 2'd1) begin
            oq_0 <= dob;
          end else begin
            oq_0 <= oq_1;
            oq_1 <= dob;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_full  = full_q;
  assign o_valid = (oq_cnt != 2'd0);
  assign o_dt    = oq_0;
  assign o_count = CW'(mem_cnt) + CW'(fetch_pend) + CW'(oq_cnt);

`ifdef FM_CMN_BFIFO_ERR_EN
  logic [ERR_NUM-1:0] err_q;
  logic [ERR_NUM-1:0] err_set;

  // classify this cycle's protocol violations
  always_comb begin
    err_set          = '0;
    err_set[ERR_OVF] = i_wr & full_q;
    err_set[ERR_UDF] = i_ack & ~o_valid;
  end

  // sticky error sources, cleared only by reset
  always_ff @(posedge clk_core) begin
    if (rst_core) err_q <= '0;
    else          err_q <= err_q | err_set;
  end

  assign o_err = |err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_fm_cmn_bfifo.sv
// tb_fm_cmn_bfifo: self-checking bench for fm_cmn_bfifo using a queue-based
// occupancy model plus directed literal checks and randomized traffic.
module tb_fm_cmn_bfifo;

  localparam int unsigned W     = 32;
  localparam int unsigned R     = 4;
  localparam int unsigned DEPTH = 16;

`ifdef FM_CMN_BFIFO_ERR_EN
  localparam bit ERR_BUILD = 1'b1;
`else
  localparam bit ERR_BUILD = 1'b0;
`endif

  logic          clk_core = 1'b0;
  logic          rst_core = 1'b1;
  logic          i_wr     = 1'b0;
  logic [W-1:0]  i_wdt    = '0;
  logic          i_ack    = 1'b0;
  logic          o_full;
  logic          o_valid;
  logic [W-1:0]  o_dt;
  logic [R+1:0]  o_count;
  logic          o_err;

  fm_cmn_bfifo #(
    .P_WIDTH (W),
    .P_RANGE (R)
  ) dut (
    .clk_core (clk_core),
    .rst_core (rst_core),
    .i_wr     (i_wr),
    .i_wdt    (i_wdt),
    .o_full   (o_full),
    .o_valid  (o_valid),
    .o_dt     (o_dt),
    .i_ack    (i_ack),
    .o_count  (o_count),
    .o_err    (o_err)
  );

  always #5 clk_core = ~clk_core;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: words sit in RAM, then one may be in flight, then in the
  // 2-deep head queue. All decisions use sizes before this edge's updates.
  logic [W-1:0] m_ram [$];
  logic [W-1:0] m_pend[$];
  logic [W-1:0] m_oq  [$];
  bit           m_err;

  always @(posedge clk_core) begin
    bit m_wr_ok, m_pop, m_fetch;
    if (rst_core) begin
      m_ram.delete();
      m_pend.delete();
      m_oq.delete();
      m_err = 1'b0;
    end else begin
      m_wr_ok = i_wr && (m_ram.size() != DEPTH);
      m_pop   = i_ack && (m_oq.size() != 0);
      m_fetch = (m_ram.size() != 0) &&
                ((m_oq.size() + m_pend.size() - int'(m_pop)) < 2);
      if ((i_wr && !m_wr_ok) || (i_ack && !m_pop)) m_err = ERR_BUILD;
      if (m_pop) void'(m_oq.pop_front());
      if (m_pend.size() != 0) m_oq.push_back(m_pend.pop_front());
      if (m_fetch) m_pend.push_back(m_ram.pop_front());
      if (m_wr_ok) m_ram.push_back(i_wdt);
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk_core) begin
    if (chk_en) begin
      check("valid", 32'(o_valid), 32'(m_oq.size() != 0));
      check("full",  32'(o_full),  32'(m_ram.size() == DEPTH));
      check("count", 32'(o_count), 32'(m_ram.size() + m_pend.size() + m_oq.size()));
      check("err",   32'(o_err),   32'(m_err));
      if (m_oq.size() != 0) check("dt", o_dt, m_oq[0]);
    end
  end

  // apply inputs for one cycle, return at the next negedge
  task automatic step(input bit wr, input logic [W-1:0] d, input bit ack);
    i_wr  = wr;
    i_wdt = d;
    i_ack = ack;
    @(negedge clk_core);
  endtask

  task automatic do_reset(input bit wr);
    rst_core = 1'b1;
    i_wr     = wr;
    i_wdt    = $urandom;
    i_ack    = 1'b0;
    @(negedge clk_core);
    rst_core = 1'b0;
    i_wr     = 1'b0;
  endtask

  logic [W-1:0] got[$];

  task automatic drain();
    got.delete();
    for (int k = 0; k < 60; k++) begin
      if (o_count == '0) break;
      if (o_valid) got.push_back(o_dt);
      step(1'b0, '0, 1'b1);
    end
    check("drain_empty", 32'(o_count), 32'd0);
  endtask

  initial begin
    int pops;
    logic [W-1:0] exp_seq;

    @(negedge clk_core);
    @(negedge clk_core);
    rst_core = 1'b0;
    chk_en   = 1'b1;

    // 1: reset state and first-word latency
    do_reset(1'b0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_full",  32'(o_full),  32'd0);
    check("rst_dt",    o_dt,         32'd0);
    check("rst_err",   32'(o_err),   32'd0);
    step(1'b1, 32'hA5A5_0001, 1'b0);
    check("lat_c1_count", 32'(o_count), 32'd1);
    check("lat_c1_valid", 32'(o_valid), 32'd0);
    step(1'b0, '0, 1'b0);
    check("lat_c2_valid", 32'(o_valid), 32'd0);
    step(1'b0, '0, 1'b0);
    check("lat_c3_valid", 32'(o_valid), 32'd1);
    check("lat_c3_dt",    o_dt,         32'hA5A5_0001);

    // 2: fill to total capacity, overflow write dropped, ordered drain
    do_reset(1'b0);
    for (int i = 1; i <= 18; i++) step(1'b1, 32'(i), 1'b0);
    check("fill_full",  32'(o_full),  32'd1);
    check("fill_count", 32'(o_count), 32'd18);
    step(1'b1, 32'd19, 1'b0);
    check("ovf_count", 32'(o_count), 32'd18);
    drain();
    check("fill_drain_n", 32'(got.size()), 32'd18);
    foreach (got[i]) check("fill_drain_word", got[i], 32'(i + 1));

    // 3: streaming write+ack, pointers wrap 6+ times
    do_reset(1'b0);
    pops    = 0;
    exp_seq = 32'd1000;
    for (int c = 0; c < 100; c++) begin
      if (o_valid) begin
        check("stream_word", o_dt, exp_seq);
        exp_seq++;
        pops++;
      end
      step(1'b1, 32'(1000 + c), 1'b1);
    end
    check("stream_pops", 32'(pops), 32'd97);
    drain();

    // 4: simultaneous write and pop at count 1
    do_reset(1'b0);
    step(1'b1, 32'h4000, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check("wp_pre_count", 32'(o_count), 32'd1);
    check("wp_pre_dt",    o_dt,         32'h4000);
    step(1'b1, 32'h4001, 1'b1);
    check("wp_count", 32'(o_count), 32'd1);
    drain();
    check("wp_drain_n", 32'(got.size()), 32'd1);
    if (got.size() != 0) check("wp_drain_word", got[0], 32'h4001);

    // 5: reset while holding 10 words with a write pending
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'(32'h500 + i), 1'b0);
    check("r5_pre_count", 32'(o_count), 32'd10);
    do_reset(1'b1);
    check("r5_valid", 32'(o_valid), 32'd0);
    check("r5_count", 32'(o_count), 32'd0);
    check("r5_full",  32'(o_full),  32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0);
    check("r5_nostore", 32'(o_count), 32'd0);

    // 6: underflow ack, sticky until reset
    do_reset(1'b0);
    step(1'b0, '0, 1'b1);
    check("udf_err", 32'(o_err), 32'(ERR_BUILD));
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    check("udf_hold", 32'(o_err), 32'(ERR_BUILD));
    do_reset(1'b0);
    check("udf_clr", 32'(o_err), 32'd0);

    // randomized traffic with varied densities and occasional resets
    for (int ph = 0; ph < 4; ph++) begin
      int unsigned pw, pa;
      pw = (ph == 0) ? 80 : (ph == 1) ? 30 : (ph == 2) ? 95 : 50;
      pa = (ph == 0) ? 30 : (ph == 1) ? 80 : (ph == 2) ? 95 : 50;
      for (int c = 0; c < 500; c++) begin
        if ($urandom_range(0, 199) == 0) begin
          do_reset($urandom_range(0, 1) == 1);
        end else begin
          step($urandom_range(0, 99) < pw, $urandom, $urandom_range(0, 99) < pa);
        end
      end
    end
    drain();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
